// File: rtl/sha_result_check.sv
// sha_result_check: pairs hashes leaving the SHA-256 pipeline with their
// nonces (issue order) and reports nonces whose hash is <= target.
//
// Optional feature macro: SHA_CHECK_STATS_EN adds the hash_count port.
//
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   issue_en/issue_nonce push a nonce when a message enters the pipeline
//   hash_en/hash         pipeline output; pops the head nonce
//   target               256-bit unsigned threshold (stable while in flight)
//   flush                synchronous clear of FIFO, result and error flags
//   found_valid/_nonce   held qualifying nonce, consumed with found_ready
//   found_lost           sticky: a qualifying nonce was dropped
//   err_overflow         sticky: push while FIFO full
//   err_underflow        sticky: hash while FIFO empty
//   hash_count           hashes checked, saturating (SHA_CHECK_STATS_EN only)

`ifndef H_SIZE
`define H_SIZE 256
`endif

module sha_result_check #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned NONCE_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 issue_en,
  input  logic [NONCE_W-1:0]   issue_nonce,
  input  logic                 hash_en,
  input  logic [`H_SIZE-1:0]   hash,
  input  logic [255:0]         target,
  input  logic                 flush,
  output logic                 found_valid,
  output logic [NONCE_W-1:0]   found_nonce,
  input  logic                 found_ready,
  output logic                 found_lost,
  output logic                 err_overflow,
  output logic                 err_underflow
`ifdef SHA_CHECK_STATS_EN
  ,
  output logic [31:0]          hash_count
`endif
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef enum logic {S_IDLE = 1'b0, S_HELD = 1'b1} state_t;

  logic [NONCE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  state_t             state;

  logic               full;
  logic               empty;
  logic               push_ok;
  logic               pop_ok;
  logic               pop_hit;
  logic [NONCE_W-1:0] head;

  // Full/empty use pre-cycle occupancy; a full FIFO drops the push even with a pop.
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == CNT_W'(0));
  assign push_ok = issue_en && !full;
  assign pop_ok  = hash_en && !empty;
  assign head    = mem[rd_ptr];
  assign pop_hit = pop_ok && (256'(hash) <= target);

  assign found_valid = (state == S_HELD);

  // Nonce storage; contents need no reset since occupancy gates every read.
  always_ff @(posedge clk) begin
    if (!flush && push_ok) mem[wr_ptr] <= issue_nonce;
  end

  // FIFO pointers, occupancy and sticky bookkeeping errors.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else if (flush) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
      if (issue_en && full) err_overflow  <= 1'b1;
      if (hash_en && empty) err_underflow <= 1'b1;
    end
  end

  // One-entry result register with drop detection under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      found_nonce <= '0;
      found_lost  <= 1'b0;
    end else if (flush) begin
      state       <= S_IDLE;
      found_nonce <= '0;
      found_lost  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop_hit) begin
            state       <= S_HELD;
            found_nonce <= head;
          end
        end
        S_HELD: begin
          if (found_ready) begin
            if (pop_hit) found_nonce <= head;
            else         state       <= S_IDLE;
          end else if (pop_hit) begin
            found_lost <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef SHA_CHECK_STATS_EN
  // Saturating count of hashes that popped a valid entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hash_count <= '0;
    end else if (flush) begin
      hash_count <= '0;
    end else if (pop_ok && (hash_count != 32'hFFFF_FFFF)) begin
      hash_count <= hash_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sha_result_check.sv
// Randomized bench for sha_result_check against a queue-based reference model.
module tb_sha_result_check;

  localparam int unsigned DEPTH   = 16;
  localparam int unsigned NONCE_W = 32;
  localparam logic [255:0] ALL_ONES = {256{1'b1}};

  logic                clk = 1'b0;
  logic                reset;
  logic                issue_en;
  logic [NONCE_W-1:0]  issue_nonce;
  logic                hash_en;
  logic [255:0]        hash;
  logic [255:0]        target;
  logic                flush;
  logic                found_valid;
  logic [NONCE_W-1:0]  found_nonce;
  logic                found_ready;
  logic                found_lost;
  logic                err_overflow;
  logic                err_underflow;
`ifdef SHA_CHECK_STATS_EN
  logic [31:0]         hash_count;
`endif

  sha_result_check #(.DEPTH(DEPTH), .NONCE_W(NONCE_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .issue_en     (issue_en),
    .issue_nonce  (issue_nonce),
    .hash_en      (hash_en),
    .hash         (hash),
    .target       (target),
    .flush        (flush),
    .found_valid  (found_valid),
    .found_nonce  (found_nonce),
    .found_ready  (found_ready),
    .found_lost   (found_lost),
    .err_overflow (err_overflow),
    .err_underflow(err_underflow)
`ifdef SHA_CHECK_STATS_EN
    ,
    .hash_count   (hash_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [NONCE_W-1:0] m_q[$];
  logic               m_valid;
  logic [NONCE_W-1:0] m_nonce;
  logic               m_lost;
  logic               m_ovf;
  logic               m_unf;
  logic [31:0]        m_cnt;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    m_valid = 1'b0;
    m_nonce = '0;
    m_lost  = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_cnt   = '0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 64'(found_valid), 64'(m_valid));
    check({tag, ".nonce"}, 64'(found_nonce), 64'(m_nonce));
    check({tag, ".lost"},  64'(found_lost),  64'(m_lost));
    check({tag, ".ovf"},   64'(err_overflow), 64'(m_ovf));
    check({tag, ".unf"},   64'(err_underflow), 64'(m_unf));
`ifdef SHA_CHECK_STATS_EN
    check({tag, ".count"}, 64'(hash_count), 64'(m_cnt));
`endif
  endtask

  // One clock cycle: drive inputs, advance the model, compare after the edge.
  task automatic step(input string tag, input logic ie, input logic [NONCE_W-1:0] nn,
                      input logic he, input logic [255:0] hh, input logic rdy, input logic fl);
    int unsigned        sz0;
    logic               popped;
    logic [NONCE_W-1:0] pn;
    logic               hit;
    issue_en    = ie;
    issue_nonce = nn;
    hash_en     = he;
    hash        = hh;
    found_ready = rdy;
    flush       = fl;
    if (fl) begin
      model_clear();
    end else begin
      sz0    = m_q.size();
      popped = 1'b0;
      pn     = '0;
      if (he) begin
        if (sz0 == 0) m_unf = 1'b1;
        else begin
          pn     = m_q.pop_front();
          popped = 1'b1;
        end
      end
      if (ie) begin
        if (sz0 == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(nn);
      end
      hit = popped && (hh <= target);
      if (m_valid) begin
        if (rdy) begin
          if (hit) m_nonce = pn;
          else     m_valid = 1'b0;
        end else if (hit) m_lost = 1'b1;
      end else if (hit) begin
        m_valid = 1'b1;
        m_nonce = pn;
      end
      if (popped && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 32'd1;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    issue_en = 1'b0; issue_nonce = '0; hash_en = 1'b0; hash = '0;
    found_ready = 1'b0; flush = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] v;
    for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Queue 6 nonces then hit the first with no ready: 5 queued, found_valid=1.
  task automatic fill_and_hold(input logic [NONCE_W-1:0] base);
    for (int i = 0; i < 6; i++) step("fill", 1'b1, base + NONCE_W'(i), 1'b0, '0, 1'b0, 1'b0);
    step("hold", 1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
    check("hold.valid", 64'(found_valid), 64'd1);
  endtask

  initial begin
    target = 256'hFF;
    do_reset();

    // 1. Order and hit.
    step("t1.i0", 1'b1, 32'h10, 1'b0, '0, 1'b1, 1'b0);
    step("t1.i1", 1'b1, 32'h11, 1'b0, '0, 1'b1, 1'b0);
    step("t1.i2", 1'b1, 32'h12, 1'b0, '0, 1'b1, 1'b0);
    step("t1.h0", 1'b0, '0, 1'b1, ALL_ONES, 1'b1, 1'b0);
    check("t1.h0.noval", 64'(found_valid), 64'd0);
    step("t1.h1", 1'b0, '0, 1'b1, 256'h1, 1'b1, 1'b0);
    check("t1.h1.valid", 64'(found_valid), 64'd1);
    check("t1.h1.nonce", 64'(found_nonce), 64'h11);
    step("t1.h2", 1'b0, '0, 1'b1, ALL_ONES, 1'b1, 1'b0);
    check("t1.h2.noval", 64'(found_valid), 64'd0);

    // 2. Backpressure: second hit dropped, then accepted.
    step("t2.i0", 1'b1, 32'h20, 1'b0, '0, 1'b0, 1'b0);
    step("t2.i1", 1'b1, 32'h21, 1'b0, '0, 1'b0, 1'b0);
    step("t2.h0", 1'b0, '0, 1'b1, 256'h5, 1'b0, 1'b0);
    step("t2.h1", 1'b0, '0, 1'b1, 256'h6, 1'b0, 1'b0);
    check("t2.keep", 64'(found_nonce), 64'h20);
    check("t2.lost", 64'(found_lost), 64'd1);
    step("t2.fl", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    step("t2.i2", 1'b1, 32'h22, 1'b0, '0, 1'b0, 1'b0);
    step("t2.i3", 1'b1, 32'h23, 1'b0, '0, 1'b0, 1'b0);
    step("t2.h2", 1'b0, '0, 1'b1, 256'h5, 1'b0, 1'b0);
    step("t2.h3", 1'b0, '0, 1'b1, 256'h6, 1'b1, 1'b0);
    check("t2.take", 64'(found_nonce), 64'h23);
    check("t2.nolost", 64'(found_lost), 64'd0);

    // 3. Overflow, then ordered drain.
    step("t3.fl", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 17; i++) step("t3.push", 1'b1, NONCE_W'(i), 1'b0, '0, 1'b0, 1'b0);
    check("t3.ovf", 64'(err_overflow), 64'd1);
    for (int i = 0; i < 16; i++) begin
      step("t3.drain", 1'b0, '0, 1'b1, '0, 1'b1, 1'b0);
      check("t3.order", 64'(found_nonce), 64'(i));
    end
    step("t3.fl2", 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step("t3.refill", 1'b1, NONCE_W'(32'h100 + i), 1'b0, '0, 1'b1, 1'b0);
    step("t3.pp", 1'b1, 32'hDEAD, 1'b1, '0, 1'b1, 1'b0);
    check("t3.pp.ovf", 64'(err_overflow), 64'd1);
    for (int i = 0; i < 15; i++) step("t3.drain2", 1'b0, '0, 1'b1, '0, 1'b1, 1'b0);
    check("t3.last", 64'(found_nonce), 64'h10F);

    // 4. Underflow.
    step("t4.h", 1'b0, '0, 1'b1, '0, 1'b1, 1'b0);
    step("t4.idle", 1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    step("t4.fl", 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    step("t4.unf", 1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
    check("t4.unf", 64'(err_underflow), 64'd1);
    check("t4.noval", 64'(found_valid), 64'd0);

    // 5. Boundary compare.
    step("t5.fl", 1'b0, '0, 1'b0, '0, 1'b1, 1'b1);
    target = rand256() >> 1;
    step("t5.i0", 1'b1, 32'h50, 1'b0, '0, 1'b1, 1'b0);
    step("t5.i1", 1'b1, 32'h51, 1'b0, '0, 1'b1, 1'b0);
    step("t5.eq", 1'b0, '0, 1'b1, target, 1'b1, 1'b0);
    check("t5.eq.hit", 64'(found_valid), 64'd1);
    step("t5.p1", 1'b0, '0, 1'b1, target + 256'd1, 1'b1, 1'b0);
    check("t5.p1.miss", 64'(found_valid), 64'd0);
    target = ALL_ONES;
    for (int i = 0; i < 8; i++) step("t5.ones.i", 1'b1, NONCE_W'(32'h60 + i), 1'b0, '0, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      step("t5.ones.h", 1'b0, '0, 1'b1, (i == 0) ? ALL_ONES : rand256(), 1'b1, 1'b0);
      check("t5.ones.hit", 64'(found_valid), 64'd1);
    end

    // 6a. Asynchronous reset mid-operation.
    target = 256'hFF;
    step("t6.fl", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    fill_and_hold(32'h70);
    #2;
    reset = 1'b1;
    issue_en = 1'b0; hash_en = 1'b0;
    #1;
    model_clear();
    check_outputs("t6.async");
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step("t6.i", 1'b1, 32'h80, 1'b0, '0, 1'b0, 1'b0);
    step("t6.h", 1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
    check("t6.fresh", 64'(found_nonce), 64'h80);
`ifdef SHA_CHECK_STATS_EN
    check("t6.count1", 64'(hash_count), 64'd1);
`endif

    // 6b. Flush with entries queued and a nonce held.
    fill_and_hold(32'h90);
    step("t6.flush", 1'b1, 32'hBAD, 1'b1, '0, 1'b0, 1'b1);
    check("t6.fl.valid", 64'(found_valid), 64'd0);
    check("t6.fl.nonce", 64'(found_nonce), 64'd0);
    step("t6.i2", 1'b1, 32'hA0, 1'b0, '0, 1'b0, 1'b0);
    step("t6.h2", 1'b0, '0, 1'b1, '0, 1'b0, 1'b0);
    check("t6.fresh2", 64'(found_nonce), 64'hA0);
`ifdef SHA_CHECK_STATS_EN
    check("t6.count2", 64'(hash_count), 64'd1);
`endif

    // Randomized traffic across several targets.
    for (int ph = 0; ph < 4; ph++) begin
      step("rnd.fl", 1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
      target = rand256() >> ($urandom_range(0, 8));
      for (int c = 0; c < 300; c++) begin
        logic [255:0] hh;
        logic         ie;
        logic         he;
        case ($urandom_range(0, 4))
          0: hh = target;
          1: hh = (target == ALL_ONES) ? target : target + 256'($urandom_range(1, 3));
          2: hh = target - 256'($urandom_range(0, 1000));
          default: hh = rand256();
        endcase
        ie = ($urandom_range(0, 99) < 55);
        he = ($urandom_range(0, 99) < ((m_q.size() > 0) ? 50 : 3));
        step("rnd", ie, NONCE_W'($urandom), he, hh, 1'($urandom_range(0, 1)), 1'b0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
